// File: rtl/snitch_icache_perf_counters.sv
// -----------------------------------------------------------------------------
// snitch_icache_perf_counters
//
// Purpose:
//   Event counters for the Snitch instruction cache. Each fetch port (L0) has
//   five single-cycle event pulses and the shared L1 has four. Every pulse
//   drives its own CNT_W-bit counter, which also has a sticky overflow flag.
//   Any counter can be read through a valid/ready request and response pair.
//   The read value is the counter's value at the start of the accepting cycle.
//
// Counter index map (NR_FETCH_PORTS = P):
//   5*p + {0..4} : L0 port p -> miss, hit, prefetch, double_hit, stall
//   5*P + {0..3} : L1        -> miss, hit, stall, handler_stall
//   Any index >= 5*P+4 returns data 0 with rsp_err_o set.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   enable_i     counting enable
//   clear_i      synchronous clear of all counters and overflow flags
//   l0_events_i  per-port L0 event pulses
//   l1_events_i  L1 event pulses
//   rd_valid_i   read request valid    rd_ready_o  read request ready
//   rd_addr_i    counter index to read
//   rsp_valid_o  response valid        rsp_ready_i response ready
//   rsp_data_o   counter value (0 while rsp_valid_o is low)
//   rsp_err_o    index out of range (0 while rsp_valid_o is low)
//   overflow_o   OR of all sticky overflow flags
//
// Configuration:
//   SNITCH_ICACHE_PERF_SATURATE_EN: when defined, a counter at its maximum
//   value holds there on increment. When undefined (the default), it wraps
//   to 0. The overflow flag sets in both builds.
// -----------------------------------------------------------------------------

package snitch_icache_perf_pkg;

    // Bit e of the packed struct is event e of the index map.
    typedef struct packed {
        logic l0_stall;
        logic l0_double_hit;
        logic l0_prefetch;
        logic l0_hit;
        logic l0_miss;
    } icache_l0_events_t;

    typedef struct packed {
        logic l1_handler_stall;
        logic l1_stall;
        logic l1_hit;
        logic l1_miss;
    } icache_l1_events_t;

endpackage

module snitch_icache_perf_counters
    import snitch_icache_perf_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 1,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned ADDR_W         = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
    input  icache_l1_events_t                      l1_events_i,
    input  logic                                   rd_valid_i,
    output logic                                   rd_ready_o,
    input  logic [ADDR_W-1:0]                      rd_addr_i,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [CNT_W-1:0]                       rsp_data_o,
    output logic                                   rsp_err_o,
    output logic                                   overflow_o
);

    localparam int unsigned       NUM_CNT = 5 * NR_FETCH_PORTS + 4;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    logic [NUM_CNT-1:0] evt_s;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_d;
    logic               ovf_any_q;
    logic               ovf_any_d;

    logic [CNT_W-1:0]   sel_data_s;
    logic               sel_hit_s;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   rsp_data_q;
    logic [CNT_W-1:0]   rsp_data_d;
    logic               rsp_err_q;
    logic               rsp_err_d;

    // Flatten the event structs into one vector ordered by counter index.
    always_comb begin
        evt_s = '0;
        for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
            evt_s[5*p +: 5] = l0_events_i[p];
        end
        evt_s[5*NR_FETCH_PORTS +: 4] = l1_events_i;
    end

    // Next counter and overflow values. Clear takes priority over increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (enable_i && evt_s[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
                    cnt_d[i] = CNT_MAX;
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        // Registered alongside the flags so overflow_o tracks them in the same cycle.
        ovf_any_d = |ovf_d;
    end

    // Counter, overflow flag and overflow summary registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q     <= '0;
            ovf_any_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q     <= ovf_d;
            ovf_any_q <= ovf_any_d;
        end
    end

    // AND-OR read mux. An out-of-range index matches nothing, so the data is 0
    // and sel_hit_s stays low.
    always_comb begin
        sel_data_s = '0;
        sel_hit_s  = 1'b0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            sel_hit_s  = sel_hit_s | (rd_addr_i == ADDR_W'(i));
            sel_data_s = sel_data_s | (cnt_q[i] & {CNT_W{rd_addr_i == ADDR_W'(i)}});
        end
    end

    // Read FSM next state and response register updates.
    // The response registers return to 0 when the response completes, so the
    // outputs read as 0 while no response is pending.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_valid_i) begin
                    state_d    = ST_RESP;
                    rsp_data_d = sel_data_s;
                    rsp_err_d  = ~sel_hit_s;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d    = ST_RESP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end
        endcase
    end

    // Read FSM state and response registers. Reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rd_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign overflow_o  = ovf_any_q;

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// -----------------------------------------------------------------------------
// Testbench for snitch_icache_perf_counters (NR_FETCH_PORTS=2, CNT_W=8).
// Read requests push their hand-computed response onto a scoreboard queue.
// A monitor pops the queue on every completed response handshake and compares.
// Inputs change 1 time unit after the rising edge, and the monitor samples on
// the falling edge.
// -----------------------------------------------------------------------------

module tb_snitch_icache_perf_counters;
    import snitch_icache_perf_pkg::*;

    localparam int unsigned NRP = 2;
    localparam int unsigned CW  = 8;
    localparam int unsigned AW  = 8;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                enable_i;
    logic                clear_i;
    logic [NRP-1:0][4:0] l0_ev;
    logic [3:0]          l1_ev;
    logic                rd_valid_i;
    logic                rd_ready_o;
    logic [AW-1:0]       rd_addr_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [CW-1:0]       rsp_data_o;
    logic                rsp_err_o;
    logic                overflow_o;

    int                  n_vec = 0;
    int                  n_err = 0;
    logic [CW:0]         sb_q[$];   // {err, data}
    logic [CW:0]         mon_exp;

    always #5 clk = ~clk;

    snitch_icache_perf_counters #(
        .NR_FETCH_PORTS (NRP),
        .CNT_W          (CW),
        .ADDR_W         (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .l0_events_i (l0_ev),
        .l1_events_i (l1_ev),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .overflow_o  (overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_l0(input int p, input int e, input int n);
        l0_ev[p][e] = 1'b1;
        repeat (n) tick();
        l0_ev[p][e] = 1'b0;
    endtask

    task automatic pulse_l1(input int e, input int n);
        l1_ev[e] = 1'b1;
        repeat (n) tick();
        l1_ev[e] = 1'b0;
    endtask

    task automatic start_read(input int a, input int d, input bit e);
        sb_q.push_back({e, CW'(d)});
        rd_addr_i  = AW'(a);
        rd_valid_i = 1'b1;
    endtask

    // Accept the request, drop all event inputs, check 1-cycle latency, complete.
    task automatic end_read();
        int n = 0;
        while (rd_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: rd_ready_o stayed %b, expected 1", rd_ready_o);
        end
        tick();
        rd_valid_i = 1'b0;
        l0_ev      = '0;
        l1_ev      = '0;
        check("rsp_latency", 32'(rsp_valid_o), 32'd1);
        tick();
        check("rsp_done_valid", 32'(rsp_valid_o), 32'd0);
        check("rsp_done_data", 32'(rsp_data_o), 32'd0);
    endtask

    task automatic read(input int a, input int d, input bit e);
        start_read(a, d, e);
        end_read();
    endtask

    // Monitor: compare every completed response against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got data %0d err %0b, expected no response",
                             rsp_data_o, rsp_err_o);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("rsp_data", 32'(rsp_data_o), 32'(mon_exp[CW-1:0]));
                    check("rsp_err", 32'(rsp_err_o), 32'(mon_exp[CW]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        enable_i    = 1'b0;
        clear_i     = 1'b0;
        l0_ev       = '0;
        l1_ev       = '0;
        rd_valid_i  = 1'b0;
        rd_addr_i   = '0;
        rsp_ready_i = 1'b1;
        #1;
        check("rst_rd_ready", 32'(rd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        tick();
        tick();
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        tick();

        // Ten hits on port 0.
        pulse_l0(0, 1, 10);
        read(1, 10, 1'b0);

        // Three separated L1 stalls; index 14 and 255 are out of range.
        for (int k = 0; k < 3; k++) begin
            pulse_l1(2, 1);
            tick();
        end
        read(12, 3, 1'b0);
        read(14, 0, 1'b1);
        read(255, 0, 1'b1);

        // Disabled counting holds; then all events in one cycle.
        enable_i = 1'b0;
        pulse_l0(1, 0, 5);
        enable_i = 1'b1;
        read(5, 0, 1'b0);
        pulse_l0(1, 0, 2);
        l0_ev = '1;
        l1_ev = '1;
        tick();
        l0_ev = '0;
        l1_ev = '0;
        read(5, 3, 1'b0);
        read(1, 11, 1'b0);
        read(9, 1, 1'b0);
        read(12, 4, 1'b0);
        read(13, 1, 1'b0);

        // Request accepted in the same cycle as an increment of counter 0.
        pulse_l0(0, 0, 3);
        start_read(0, 4, 1'b0);
        l0_ev[0][0] = 1'b1;
        end_read();
        read(0, 5, 1'b0);

        // Clear wins over a simultaneous stall event.
        pulse_l0(0, 4, 2);
        read(4, 3, 1'b0);
        clear_i     = 1'b1;
        l0_ev[0][4] = 1'b1;
        tick();
        clear_i     = 1'b0;
        l0_ev[0][4] = 1'b0;
        check("clear_overflow", 32'(overflow_o), 32'd0);
        read(4, 0, 1'b0);
        read(1, 0, 1'b0);
        read(12, 0, 1'b0);

        // Overflow on the 8-bit prefetch counter of port 0.
        pulse_l0(0, 2, 255);
        check("ovf_at_max", 32'(overflow_o), 32'd0);
        read(2, 255, 1'b0);
        pulse_l0(0, 2, 1);
        check("ovf_set", 32'(overflow_o), 32'd1);
        read(2, SAT ? 255 : 0, 1'b0);
        pulse_l0(0, 2, 1);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        read(2, SAT ? 255 : 1, 1'b0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("ovf_cleared", 32'(overflow_o), 32'd0);

        // Back-pressure: response held stable while rsp_ready_i is low.
        pulse_l1(1, 7);
        rsp_ready_i = 1'b0;
        start_read(11, 7, 1'b0);
        tick();
        rd_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_data", 32'(rsp_data_o), 32'd7);
            check("stall_err", 32'(rsp_err_o), 32'd0);
            check("stall_rd_ready", 32'(rd_ready_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        check("stall_done", 32'(rsp_valid_o), 32'd0);

        // Reset while a response is pending drops it.
        rsp_ready_i = 1'b0;
        rd_addr_i   = AW'(11);
        rd_valid_i  = 1'b1;
        tick();
        rd_valid_i  = 1'b0;
        check("pend_valid", 32'(rsp_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("async_rst_ready", 32'(rd_ready_o), 32'd1);
        check("async_rst_data", 32'(rsp_data_o), 32'd0);
        tick();
        tick();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
            tick();
        end
        read(11, 0, 1'b0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
